// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arb_pkg;

  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rtl/mem_arbiter_rr_pick2.sv - two-way round-robin winner select
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last,
  output owner_t winner
);

  // On a tie the requester that was not served last gets the memory.
  always_comb begin
    winner = OWN_I;
    if (i_req && d_req) begin
      winner = (last == OWN_I) ? OWN_D : OWN_I;
    end else if (d_req) begin
      winner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter for a single fixed-latency memory port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        d_req,
  input  logic        i_write_en,
  input  logic        d_write_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_data,
  output logic        i_ack,
  output logic        d_ack,
  output logic [31:0] i_out,
  output logic [31:0] d_out,
  output logic [1:0]  grant,
  output logic        mwrite_en,
  output logic [31:0] maddr,
  output logic [31:0] mdata,
  input  logic [31:0] mout
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(LATENCY - 1);

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  owner_t                 owner;
  owner_t                 last;
  owner_t                 winner;
  owner_t                 next_owner;
  logic                   start;
  logic                   owner_req;
  logic                   other_req;
  logic [31:0]            addr_q;
  logic [31:0]            data_q;
  logic                   we_q;
  logic [31:0]            rdata;

  rr_pick2 u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .last   (last),
    .winner (winner)
  );

  // Leaving DONE, the current owner keeps the port while it still requests.
  always_comb begin
    owner_req  = (owner == OWN_I) ? i_req : d_req;
    other_req  = (owner == OWN_I) ? d_req : i_req;
    start      = 1'b0;
    next_owner = owner;
    case (state)
      IDLE: begin
        start      = i_req | d_req;
        next_owner = winner;
      end
      DONE: begin
        start = owner_req | other_req;
        if (!owner_req) begin
          next_owner = (owner == OWN_I) ? OWN_D : OWN_I;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      owner  <= OWN_I;
      last   <= OWN_I;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      rdata  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= ACCESS;
            cnt    <= '0;
            owner  <= next_owner;
            last   <= next_owner;
            addr_q <= (next_owner == OWN_I) ? i_addr : d_addr;
            data_q <= (next_owner == OWN_I) ? i_data : d_data;
            we_q   <= (next_owner == OWN_I) ? i_write_en : d_write_en;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            rdata <= mout;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant[0]  = (state != IDLE) && (owner == OWN_I);
  assign grant[1]  = (state != IDLE) && (owner == OWN_D);
  // Writes are issued once, in the first cycle of the access window.
  assign mwrite_en = (state == ACCESS) && (cnt == '0) && we_q;
  assign maddr     = addr_q;
  assign mdata     = data_q;
  assign i_ack     = (state == DONE) && (owner == OWN_I);
  assign d_ack     = (state == DONE) && (owner == OWN_D);
  assign i_out     = rdata;
  assign d_out     = rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed checks of mem_arbiter at LATENCY 2 and 3
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, i_we, d_we;
  logic [31:0] i_addr, i_data, d_addr, d_data;

  logic        i_ack2, d_ack2, mwe2, i_ack3, d_ack3, mwe3;
  logic [31:0] i_out2, d_out2, maddr2, mdata2, mout2;
  logic [31:0] i_out3, d_out3, maddr3, mdata3, mout3;
  logic [1:0]  grant2, grant3;

  logic        wr_ok2, wr_ok3;
  logic [31:0] wr_addr2, wr_data2, wr_addr3, wr_data3;

  int tests = 0;
  int fails = 0;
  int k, ack_c, ack_n, we_n, we_c;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .i_req(i_req), .d_req(d_req),
    .i_write_en(i_we), .d_write_en(d_we), .i_addr(i_addr), .i_data(i_data),
    .d_addr(d_addr), .d_data(d_data), .i_ack(i_ack2), .d_ack(d_ack2),
    .i_out(i_out2), .d_out(d_out2), .grant(grant2), .mwrite_en(mwe2),
    .maddr(maddr2), .mdata(mdata2), .mout(mout2)
  );

  mem_arbiter #(.LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .i_req(i_req), .d_req(d_req),
    .i_write_en(i_we), .d_write_en(d_we), .i_addr(i_addr), .i_data(i_data),
    .d_addr(d_addr), .d_data(d_data), .i_ack(i_ack3), .d_ack(d_ack3),
    .i_out(i_out3), .d_out(d_out3), .grant(grant3), .mwrite_en(mwe3),
    .maddr(maddr3), .mdata(mdata3), .mout(mout3)
  );

  // Memory model: fixed pattern, overridden by the most recent write.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hA5A50000 ^ a;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      wr_ok2 <= 1'b0;
      wr_ok3 <= 1'b0;
    end else begin
      if (mwe2) begin
        wr_ok2 <= 1'b1; wr_addr2 <= maddr2; wr_data2 <= mdata2;
      end
      if (mwe3) begin
        wr_ok3 <= 1'b1; wr_addr3 <= maddr3; wr_data3 <= mdata3;
      end
    end
  end

  assign mout2 = (wr_ok2 && wr_addr2 == maddr2) ? wr_data2 : pat(maddr2);
  assign mout3 = (wr_ok3 && wr_addr3 == maddr3) ? wr_data3 : pat(maddr3);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_req = 1'b0; d_req = 1'b0; i_we = 1'b0; d_we = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b0;
    i_req = 1'b0; d_req = 1'b0; i_we = 1'b0; d_we = 1'b0;
    i_addr = '0; i_data = '0; d_addr = '0; d_data = '0;
    tick(); tick();
    check("rst_grant", grant2, 2'b00);
    check("rst_i_ack", i_ack2, 0);
    check("rst_d_ack", d_ack2, 0);
    check("rst_mwe", mwe2, 0);
    check("rst_maddr", maddr2, 0);
    check("rst_mdata", mdata2, 0);
    check("rst_i_out", i_out2, 0);
    check("rst_d_out", d_out2, 0);
    reset = 1'b1;
    tick();

    // icache read, LATENCY 2
    i_req = 1'b1; i_addr = 32'h100;
    check("rd_idle_grant", grant2, 2'b00);
    tick();
    check("rd_c1_grant", grant2, 2'b01);
    check("rd_c1_maddr", maddr2, 32'h100);
    check("rd_c1_mwe", mwe2, 0);
    tick();
    check("rd_c2_maddr", maddr2, 32'h100);
    check("rd_c2_ack", i_ack2, 0);
    i_req = 1'b0;
    tick();
    check("rd_c3_i_ack", i_ack2, 1);
    check("rd_c3_d_ack", d_ack2, 0);
    check("rd_c3_i_out", i_out2, 32'hA5A50100);
    check("rd_c3_d_out", d_out2, 32'hA5A50100);
    tick();
    check("rd_c4_grant", grant2, 2'b00);
    check("rd_c4_ack", i_ack2, 0);
    idle(6);

    // tie after reset: dcache first, then icache, then next tie to dcache
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h10; d_addr = 32'h8;
    tick();
    check("tie_c1_grant", grant2, 2'b10);
    check("tie_c1_maddr", maddr2, 32'h8);
    tick(); tick();
    check("tie_c3_d_ack", d_ack2, 1);
    check("tie_c3_i_ack", i_ack2, 0);
    check("tie_c3_d_out", d_out2, 32'hA5A50008);
    d_req = 1'b0;
    tick();
    check("tie_c4_grant", grant2, 2'b01);
    check("tie_c4_maddr", maddr2, 32'h10);
    tick(); tick();
    check("tie_c6_i_ack", i_ack2, 1);
    check("tie_c6_i_out", i_out2, 32'hA5A50010);
    i_req = 1'b0;
    tick();
    check("tie_c7_grant", grant2, 2'b00);
    i_req = 1'b1; d_req = 1'b1;
    tick();
    check("tie2_c8_grant", grant2, 2'b10);
    i_req = 1'b0; d_req = 1'b0;
    tick(); tick();
    check("tie2_c10_d_ack", d_ack2, 1);
    idle(6);

    // icache 4-beat burst with dcache waiting; dcache was served last
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h200; d_addr = 32'h300;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (i_ack2) begin
        check("burst_ack_cycle", c, 3 * (k + 1));
        check("burst_i_out", i_out2, 32'hA5A50200 + 4 * k);
        check("burst_no_d_ack", d_ack2, 0);
        k++;
        if (k == 4) begin
          i_req = 1'b0;
          break;
        end
        i_addr = 32'h200 + 4 * k;
      end
    end
    check("burst_beats", k, 4);
    tick();
    check("burst_d_grant", grant2, 2'b10);
    check("burst_d_maddr", maddr2, 32'h300);
    idle(6);

    // dcache write, LATENCY 3
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_data = 32'hDEADBEEF;
    we_n = 0; we_c = 0; ack_n = 0; ack_c = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) begin
        d_req = 1'b0; d_we = 1'b0;
      end
      if (mwe3) begin we_n++; we_c = c; end
      if (d_ack3) begin ack_n++; ack_c = c; end
    end
    check("wr_mwe_count", we_n, 1);
    check("wr_mwe_cycle", we_c, 1);
    check("wr_ack_count", ack_n, 1);
    check("wr_ack_cycle", ack_c, 4);
    check("wr_mem_addr", wr_addr3, 32'h40);
    check("wr_mem_data", wr_data3, 32'hDEADBEEF);
    idle(4);

    // reset during cnt==1 of a write, LATENCY 3
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_data = 32'h12345678;
    tick();
    check("ra_c1_mwe", mwe3, 1);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("ra_grant", grant3, 2'b00);
    check("ra_mwe", mwe3, 0);
    check("ra_maddr", maddr3, 0);
    check("ra_mdata", mdata3, 0);
    check("ra_d_out", d_out3, 0);
    check("ra_i_out", i_out3, 0);
    check("ra_d_ack", d_ack3, 0);
    check("ra_i_ack", i_ack3, 0);
    ack_n = 0;
    repeat (3) begin
      tick();
      if (d_ack3) ack_n++;
    end
    reset = 1'b1;
    tick();
    if (d_ack3) ack_n++;
    check("ra_no_ack", ack_n, 0);
    check("ra_idle_grant", grant3, 2'b00);
    d_req = 1'b1; d_addr = 32'h48;
    ack_n = 0; ack_c = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) d_req = 1'b0;
      if (d_ack3) begin
        ack_n++; ack_c = c;
        check("ra_fresh_d_out", d_out3, 32'hA5A50048);
      end
    end
    check("ra_fresh_ack_count", ack_n, 1);
    check("ra_fresh_ack_cycle", ack_c, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning memory cycles per access (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports i_req/d_req  input  1 each  icache/dcache requests memory; held high for the whole transaction or burst.
REQ-005 SHALL have ports i_write_en/d_write_en  input  1 each  access is a write when high.
REQ-006 SHALL have ports i_addr, i_data, d_addr, d_data  input  32 each  address and write data per requester.
REQ-007 SHALL have ports i_ack/d_ack  output  1 each  one-cycle pulse marking completion of one access for that requester.
REQ-008 SHALL have ports i_out/d_out  output  32 each  read data, valid while the matching ack is high.
REQ-009 SHALL have port grant  output  2  one-hot current owner; bit0 = icache, bit1 = dcache, 00 = idle.
REQ-010 SHALL have ports mwrite_en  output  1, maddr  output  32, mdata  output  32  memory command.
REQ-011 SHALL have port mout  input  32  memory read data, combinational from maddr.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, DONE plus a 4-bit cycle counter cnt.
REQ-013 IDLE: on an edge with any req high, SHALL pick a winner, latch its addr/data/write_en, set owner, cnt=0, and enter ACCESS.
REQ-014 Winner pick SHALL be round-robin: if both request, the requester not served last wins; the "last served" register resets to icache, so dcache wins the first tie.
REQ-015 ACCESS: maddr/mdata SHALL come from the latched registers for all LATENCY cycles; mwrite_en SHALL equal latched write_en only when cnt==0, else 0.
REQ-016 ACCESS: cnt SHALL increment each cycle; on the edge with cnt==LATENCY-1, mout SHALL be captured into the read register and the FSM SHALL enter DONE.
REQ-017 DONE: owner's ack SHALL be 1 for exactly this one cycle, the other ack 0; i_out and d_out both SHALL show the read register.
REQ-018 DONE exit (burst lock): if owner req is high, SHALL latch the owner's inputs and re-enter ACCESS.
REQ-019 DONE exit: otherwise, if the other req is high, SHALL switch owner, latch its inputs and enter ACCESS; otherwise SHALL enter IDLE.
REQ-020 Latency: a req first high in cycle t while IDLE SHALL produce ack in cycle t+LATENCY+1; burst throughput SHALL be one access per LATENCY+1 cycles.
REQ-021 Request inputs changing during ACCESS SHALL be ignored; they are sampled only at the edges leaving IDLE or DONE.
REQ-022 If the owner drops req during ACCESS, the access SHALL still complete, with ack pulsed in DONE.
REQ-023 grant SHALL reflect owner in ACCESS and DONE and be 00 in IDLE; mwrite_en SHALL never be high outside ACCESS.
REQ-024 A requester whose req stays high SHALL be granted no later than the end of the current owner's burst.

Reset
REQ-025 Asserting reset SHALL immediately force IDLE, cnt=0, last-served=icache, and clear latched and read registers.
REQ-026 While reset is asserted, grant=00, i_ack=d_ack=0, mwrite_en=0, and maddr=mdata=i_out=d_out=0.
REQ-027 Reset asserted mid-access SHALL abort the access with no ack; the first arbitration SHALL occur on the first edge after reset deasserts.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the state enum {IDLE, ACCESS, DONE}, the owner enum {OWN_I, OWN_D}, and the constant CNT_WIDTH=4.
REQ-029 Round-robin selection SHALL be a separate combinational sub-module rr_pick2 (inputs i_req, d_req, last; output winner); all else stays in mem_arbiter.

Verification
REQ-030 LATENCY=2; icache read of 0x100 with req high in cycle 0 -> maddr=0x100 in cycles 1-2, i_ack=1 in cycle 3, and i_out equals memory[0x100].
REQ-031 Both req high in cycle 0 after reset -> dcache served first; icache next with i_ack in cycle 6; a later tie goes to the requester not served last.
REQ-032 dcache write 0xDEADBEEF to 0x40, LATENCY=3 -> mwrite_en high exactly one cycle, memory[0x40]=0xDEADBEEF, and d_ack pulses once.
REQ-033 icache 4-word burst while d_req is high throughout -> four i_acks spaced LATENCY+1 apart, then dcache is granted in the next DONE exit.
REQ-034 Reset asserted in cnt==1 of a write, LATENCY=3 -> no ack, all outputs 0, FSM in IDLE; a fresh request after release completes normally.
